// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage 0 forms per-block candidate sums; later stages resolve SEL_PER_STAGE blocks of both carry chains per cycle.
module pipelined_csel_adder #(
    parameter int WIDTH         = 32,
    parameter int BLOCK_W       = 8,
    parameter int SEL_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] sum_alt,
    output logic             cout,
    output logic             cout_alt,
    output logic             ovf
);

    localparam int NBLOCKS = WIDTH / BLOCK_W;
    localparam int NSTAGES = NBLOCKS / SEL_PER_STAGE;

    generate
        if (BLOCK_W < 1 || SEL_PER_STAGE < 1 || (WIDTH % BLOCK_W) != 0 ||
            (NBLOCKS % SEL_PER_STAGE) != 0) begin : g_bad_params
            $error("pipelined_csel_adder: illegal WIDTH/BLOCK_W/SEL_PER_STAGE combination");
        end
    endgenerate

    // Once a block is resolved, s0 carries its primary-chain sum and s1 its alternate-chain sum.
    typedef struct packed {
        logic               vld;
        logic [WIDTH-1:0]   s0;
        logic [WIDTH-1:0]   s1;
        logic [NBLOCKS-1:0] co0;
        logic [NBLOCKS-1:0] co1;
        logic               cp;
        logic               ca;
        logic               a_msb;
        logic               b_msb;
    } stage_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] rp;
        logic [WIDTH-1:0] ra;
        logic             cp;
        logic             ca;
        logic             a_msb;
        logic             b_msb;
    } final_t;

    stage_t st_d [0:NSTAGES-1];
    stage_t st_q [0:NSTAGES-1];
    final_t fin_d;
    final_t fin_q;

    logic             en;
    logic [WIDTH-1:0] bp;
    logic             c0;
    logic [BLOCK_W:0] t0;
    logic [BLOCK_W:0] t1;

    // Resolve the j-th group of blocks for both chains, threading the chain carries through.
    function automatic void resolve(
        input  int               j,
        input  logic [WIDTH-1:0] s0_in,
        input  logic [WIDTH-1:0] s1_in,
        input  logic [NBLOCKS-1:0] co0,
        input  logic [NBLOCKS-1:0] co1,
        input  logic             cp_in,
        input  logic             ca_in,
        output logic [WIDTH-1:0] s0_out,
        output logic [WIDTH-1:0] s1_out,
        output logic             cp_out,
        output logic             ca_out
    );
        logic p;
        logic q;
        logic pn;
        logic qn;
        int   k;
        s0_out = s0_in;
        s1_out = s1_in;
        p      = cp_in;
        q      = ca_in;
        for (int i = 0; i < SEL_PER_STAGE; i++) begin
            k = (j - 1) * SEL_PER_STAGE + i;
            s0_out[k*BLOCK_W +: BLOCK_W] = p ? s1_in[k*BLOCK_W +: BLOCK_W] : s0_in[k*BLOCK_W +: BLOCK_W];
            s1_out[k*BLOCK_W +: BLOCK_W] = q ? s1_in[k*BLOCK_W +: BLOCK_W] : s0_in[k*BLOCK_W +: BLOCK_W];
            pn = p ? co1[k] : co0[k];
            qn = q ? co1[k] : co0[k];
            p  = pn;
            q  = qn;
        end
        cp_out = p;
        ca_out = q;
    endfunction

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    always_comb begin
        bp       = sub ? ~b : b;
        c0       = sub | cin;
        t0       = '0;
        t1       = '0;
        st_d[0]  = '0;
        st_d[0].vld   = in_valid;
        st_d[0].cp    = c0;
        st_d[0].ca    = ~c0;
        st_d[0].a_msb = a[WIDTH-1];
        st_d[0].b_msb = bp[WIDTH-1];
        for (int k = 0; k < NBLOCKS; k++) begin
            t0 = {1'b0, a[k*BLOCK_W +: BLOCK_W]} + {1'b0, bp[k*BLOCK_W +: BLOCK_W]};
            t1 = t0 + (BLOCK_W+1)'(1);
            st_d[0].s0[k*BLOCK_W +: BLOCK_W] = t0[BLOCK_W-1:0];
            st_d[0].s1[k*BLOCK_W +: BLOCK_W] = t1[BLOCK_W-1:0];
            st_d[0].co0[k] = t0[BLOCK_W];
            st_d[0].co1[k] = t1[BLOCK_W];
        end
        for (int j = 1; j < NSTAGES; j++) begin
            st_d[j] = st_q[j-1];
            resolve(j, st_q[j-1].s0, st_q[j-1].s1, st_q[j-1].co0, st_q[j-1].co1,
                    st_q[j-1].cp, st_q[j-1].ca,
                    st_d[j].s0, st_d[j].s1, st_d[j].cp, st_d[j].ca);
        end
        fin_d       = '0;
        fin_d.vld   = st_q[NSTAGES-1].vld;
        fin_d.a_msb = st_q[NSTAGES-1].a_msb;
        fin_d.b_msb = st_q[NSTAGES-1].b_msb;
        resolve(NSTAGES, st_q[NSTAGES-1].s0, st_q[NSTAGES-1].s1, st_q[NSTAGES-1].co0,
                st_q[NSTAGES-1].co1, st_q[NSTAGES-1].cp, st_q[NSTAGES-1].ca,
                fin_d.rp, fin_d.ra, fin_d.cp, fin_d.ca);
    end

    // A single global enable freezes the whole pipe while the consumer stalls.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NSTAGES; i++) st_q[i] <= '0;
            fin_q     <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            sum_alt   <= '0;
            cout      <= 1'b0;
            cout_alt  <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < NSTAGES; i++) st_q[i] <= st_d[i];
            fin_q     <= fin_d;
            out_valid <= fin_q.vld;
            sum       <= fin_q.rp;
            sum_alt   <= fin_q.ra;
            cout      <= fin_q.cp;
            cout_alt  <= fin_q.ca;
            ovf       <= (fin_q.a_msb == fin_q.b_msb) && (fin_q.rp[WIDTH-1] != fin_q.a_msb);
        end
    end

endmodule
